// File: rtl/cg_seq_pkg.sv
// Shared types and constants for the conjugate-gradient phase sequencer.
package cg_seq_pkg;

  localparam int unsigned NUM_PHASES = 7;
  localparam int unsigned PHASE_W    = 3;

  localparam logic [PHASE_W-1:0] PH_MXV       = 3'd0;
  localparam logic [PHASE_W-1:0] PH_VXV_PQ    = 3'd1;
  localparam logic [PHASE_W-1:0] PH_DIV_ALPHA = 3'd2;
  localparam logic [PHASE_W-1:0] PH_UPD_XR    = 3'd3;
  localparam logic [PHASE_W-1:0] PH_VXV_RR    = 3'd4;
  localparam logic [PHASE_W-1:0] PH_DIV_BETA  = 3'd5;
  localparam logic [PHASE_W-1:0] PH_UPD_P     = 3'd6;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StCheck,
    StDone,
    StError
  } seq_state_e;

endpackage

// File: rtl/cg_phase_watchdog.sv
// Per-phase wait watchdog: counts enabled cycles and flags expiry on the
// TIMEOUT_CYCLES-th consecutive enabled cycle since the last clear.
module cg_phase_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TMO_W          = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMO_W-1:0] Limit = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] cnt_q;

  assign expired = enable && (cnt_q == Limit);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + TMO_W'(1);
    end
  end

endmodule

// File: rtl/cg_phase_sequencer.sv
// Phase scheduler for the CG solver datapath: launches each compute unit in
// order, counts iterations, halts on convergence/limit and traps hung units.
// Optional cycle counter enabled by defining CG_SEQ_PERF_CNT_EN.
module cg_phase_sequencer
  import cg_seq_pkg::*;
#(
  parameter int unsigned MAX_ITER       = 20,
  parameter int unsigned ITER_W         = 11,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TMO_W          = 16,
  parameter int unsigned PERF_W         = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  converged_i,
  input  logic [NUM_PHASES-1:0] unit_done_i,
  output logic [NUM_PHASES-1:0] unit_start_o,
  output logic [PHASE_W-1:0]    phase_o,
  output logic [ITER_W-1:0]     iter_count_o,
  output logic                  busy_o,
  output logic                  halt_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [PHASE_W-1:0]    err_phase_o,
  output logic [PERF_W-1:0]     cycles_o
);

  localparam logic [ITER_W-1:0] MaxIter = ITER_W'(MAX_ITER);

  seq_state_e          state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [ITER_W-1:0]   iter_inc;
  logic                halt_q, halt_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [PHASE_W-1:0]  err_phase_q, err_phase_d;
  logic [7:0]          done_vec;
  logic                phase_done;
  logic                wdg_clear;
  logic                wdg_enable;
  logic                wdg_expired;

  // Pad to a power of two so any phase_q value indexes a real bit.
  assign done_vec   = {1'b0, unit_done_i};
  assign phase_done = done_vec[phase_q];
  assign iter_inc   = iter_q + ITER_W'(1);
  assign wdg_clear  = (state_q == StLaunch);
  assign wdg_enable = (state_q == StWait);

  cg_phase_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMO_W         (TMO_W)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wdg_clear),
    .enable (wdg_enable),
    .expired(wdg_expired)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    iter_d      = iter_q;
    halt_d      = halt_q;
    done_d      = 1'b0;
    err_d       = err_q;
    err_phase_d = err_phase_q;

    if (abort_i) begin
      if (state_q != StIdle) begin
        state_d = StIdle;
        phase_d = PH_MXV;
        halt_d  = 1'b0;
      end
    end else begin
      case (state_q)
        StIdle, StDone, StError: begin
          if (start_i) begin
            state_d     = StLaunch;
            phase_d     = PH_MXV;
            iter_d      = '0;
            halt_d      = 1'b0;
            err_d       = 1'b0;
            err_phase_d = '0;
          end
        end
        StLaunch: state_d = StWait;
        StWait: begin
          // A done in the same cycle as expiry still counts as success.
          if (phase_done) begin
            if (phase_q == PH_UPD_P) begin
              state_d = StCheck;
            end else begin
              phase_d = phase_q + PHASE_W'(1);
              state_d = StLaunch;
            end
          end else if (wdg_expired) begin
            state_d     = StError;
            err_d       = 1'b1;
            err_phase_d = phase_q;
          end
        end
        StCheck: begin
          iter_d = iter_inc;
          if (converged_i || (iter_inc == MaxIter)) begin
            state_d = StDone;
            done_d  = 1'b1;
            halt_d  = 1'b1;
          end else begin
            phase_d = PH_MXV;
            state_d = StLaunch;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      phase_q     <= PH_MXV;
      iter_q      <= '0;
      halt_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_phase_q <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      iter_q      <= iter_d;
      halt_q      <= halt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_phase_q <= err_phase_d;
    end
  end

  always_comb begin
    unit_start_o = '0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      unit_start_o[i] = (state_q == StLaunch) && (phase_q == PHASE_W'(i));
    end
  end

  assign busy_o       = (state_q == StLaunch) || (state_q == StWait) || (state_q == StCheck);
  assign phase_o      = phase_q;
  assign iter_count_o = iter_q;
  assign halt_o       = halt_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_phase_o  = err_phase_q;

`ifdef CG_SEQ_PERF_CNT_EN
  logic              start_accept;
  logic [PERF_W-1:0] cycles_q;

  assign start_accept = start_i && !abort_i &&
                        ((state_q == StIdle) || (state_q == StDone) || (state_q == StError));

  always_ff @(posedge clk) begin
    if (reset || start_accept) begin
      cycles_q <= '0;
    end else if (busy_o && (cycles_q != '1)) begin
      cycles_q <= cycles_q + PERF_W'(1);
    end
  end

  assign cycles_o = cycles_q;
`else
  assign cycles_o = '0;
`endif

endmodule

// File: tb/tb_cg_phase_sequencer.sv
// Randomized scoreboard bench for cg_phase_sequencer with a solve-level reference model.
module tb_cg_phase_sequencer;

  localparam int unsigned MAX_ITER = 3;
  localparam int unsigned ITER_W   = 11;
  localparam int unsigned TIMEOUT  = 8;
  localparam int unsigned TMO_W    = 16;
  localparam int unsigned PERF_W   = 32;
  localparam int KDONE  = 0;
  localparam int KERR   = 1;
  localparam int KABORT = 2;

  typedef struct {
    int     kind;
    int     iter;
    int     ph;
    longint start_cyc;
  } end_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start_i = 1'b0;
  logic              abort_i = 1'b0;
  logic              converged_i = 1'b0;
  logic [6:0]        unit_done_i = '0;
  logic [6:0]        unit_start_o;
  logic [2:0]        phase_o;
  logic [ITER_W-1:0] iter_count_o;
  logic              busy_o;
  logic              halt_o;
  logic              done_o;
  logic              err_o;
  logic [2:0]        err_phase_o;
  logic [PERF_W-1:0] cycles_o;

  int     n_checks = 0;
  int     n_fail = 0;
  longint cyc = 0;
  int     exp_start_q[$];
  end_t   end_q[$];
  longint timing_q[$];
  int     solve_id = 0;
  int     conv_at = 0;
  int     hang_it = 0;
  int     hang_ph = 0;
  int     abort_it = 0;
  int     abort_ph = 0;

  cg_phase_sequencer #(
    .MAX_ITER      (MAX_ITER),
    .ITER_W        (ITER_W),
    .TIMEOUT_CYCLES(TIMEOUT),
    .TMO_W         (TMO_W),
    .PERF_W        (PERF_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .converged_i (converged_i),
    .unit_done_i (unit_done_i),
    .unit_start_o(unit_start_o),
    .phase_o     (phase_o),
    .iter_count_o(iter_count_o),
    .busy_o      (busy_o),
    .halt_o      (halt_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .err_phase_o (err_phase_o),
    .cycles_o    (cycles_o)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_unit_start"}, 64'(unit_start_o), 0);
    check({tag, "_phase"}, 64'(phase_o), 0);
    check({tag, "_iter"}, 64'(iter_count_o), 0);
    check({tag, "_busy"}, 64'(busy_o), 0);
    check({tag, "_halt"}, 64'(halt_o), 0);
    check({tag, "_done"}, 64'(done_o), 0);
    check({tag, "_err"}, 64'(err_o), 0);
    check({tag, "_err_phase"}, 64'(err_phase_o), 0);
    check({tag, "_cycles"}, 64'(cycles_o), 0);
  endtask

  // Monitor: pops expected launches and solve endings as the DUT shows them.
  initial begin : monitor
    int       ph;
    int       act_kind;
    int       mon_phase;
    logic     prev_busy;
    logic     got_end;
    logic     exp_done;
    longint   last_start;
    longint   t;
    longint   exp_cyc;
    end_t     e;
    logic [6:0] exp_vec;
    prev_busy  = 1'b0;
    last_start = 0;
    mon_phase  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 1'b0;
        continue;
      end
      if (unit_start_o != '0) begin
        check("start_expected", 64'(exp_start_q.size() != 0), 1);
        if (exp_start_q.size() != 0) begin
          ph = exp_start_q.pop_front();
          exp_vec = '0;
          exp_vec[ph] = 1'b1;
          check("start_vec", 64'(unit_start_o), 64'(exp_vec));
          check("start_phase", 64'(phase_o), 64'(ph));
          mon_phase = ph;
          t = (timing_q.size() != 0) ? timing_q.pop_front() : -1;
          check("start_time", cyc, t);
        end
        last_start = cyc;
      end
      if (busy_o) check("phase_hold", 64'(phase_o), 64'(mon_phase));
      got_end = 1'b0;
      if (prev_busy && !busy_o) begin
        check("end_expected", 64'(end_q.size() != 0), 1);
        if (end_q.size() != 0) begin
          e = end_q.pop_front();
          got_end = 1'b1;
          act_kind = done_o ? KDONE : (err_o ? KERR : KABORT);
          check("end_kind", 64'(act_kind), 64'(e.kind));
          check("end_iter", 64'(iter_count_o), 64'(e.iter));
          check("end_halt", 64'(halt_o), 64'(e.kind == KDONE));
          if (e.kind == KERR) begin
            check("err_phase", 64'(err_phase_o), 64'(e.ph));
            check("err_latency", cyc - last_start, 64'(TIMEOUT + 1));
          end else if (e.kind == KABORT) begin
            check("abort_latency", cyc - last_start, 2);
          end else begin
            t = (timing_q.size() != 0) ? timing_q.pop_front() : -1;
            check("done_time", cyc, t);
          end
`ifdef CG_SEQ_PERF_CNT_EN
          exp_cyc = cyc - e.start_cyc;
`else
          exp_cyc = 0;
`endif
          check("cycles", 64'(cycles_o), exp_cyc);
        end
      end
      exp_done = got_end && (e.kind == KDONE);
      check("done_pulse", 64'(done_o), 64'(exp_done));
      prev_busy = busy_o;
    end
  end

  // Unit responder: answers launches after a random latency, adds stray done
  // bits for other phases and noise on converged_i outside CHECK.
  initial begin : responder
    int         my_solve;
    int         it_r;
    int         cnt;
    int         cur;
    int         chold;
    int         nb;
    int         lat;
    logic       abort_pend;
    logic [6:0] dv;
    my_solve   = 0;
    it_r       = 0;
    cnt        = 0;
    cur        = 0;
    chold      = 0;
    abort_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (solve_id != my_solve) begin
        my_solve   = solve_id;
        it_r       = 0;
        cnt        = 0;
        abort_pend = 1'b0;
      end
      abort_i    = abort_pend;
      abort_pend = 1'b0;
      dv = '0;
      if (chold > 0) chold--;
      else converged_i = 1'($urandom_range(0, 1));
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          dv[cur] = 1'b1;
          if (cur == 6) begin
            converged_i = (it_r == conv_at);
            chold = 2;
          end
        end
      end
      if (unit_start_o != '0) begin
        for (int i = 0; i < 7; i++) if (unit_start_o[i]) cur = i;
        if (cur == 0) it_r++;
        if (!(it_r == hang_it && cur == hang_ph)) begin
          if (it_r == abort_it && cur == abort_ph) begin
            abort_pend = 1'b1;
          end else begin
            lat = int'($urandom_range(1, 3));
            cnt = lat;
            timing_q.push_back(cyc + lat + ((cur == 6) ? 2 : 1));
          end
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        nb = int'($urandom_range(0, 6));
        if (nb != cur) dv[nb] = 1'b1;
      end
      unit_done_i = dv;
    end
  end

  // Reference model: expected launch order and solve ending from the plan.
  task automatic run_solve(input int c_at, input int h_it, input int h_ph,
                           input int a_it, input int a_ph);
    end_t e;
    int   n;
    bit   fin;
    conv_at  = c_at;
    hang_it  = h_it;
    hang_ph  = h_ph;
    abort_it = a_it;
    abort_ph = a_ph;
    solve_id++;
    exp_start_q.delete();
    end_q.delete();
    timing_q.delete();
    e.start_cyc = cyc + 1;
    e.kind = KDONE;
    e.iter = 0;
    e.ph   = 0;
    fin = 1'b0;
    for (int it = 1; it <= int'(MAX_ITER) && !fin; it++) begin
      for (int p = 0; p < 7 && !fin; p++) begin
        exp_start_q.push_back(p);
        if (it == h_it && p == h_ph) begin
          e.kind = KERR; e.iter = it - 1; e.ph = p; fin = 1'b1;
        end else if (it == a_it && p == a_ph) begin
          e.kind = KABORT; e.iter = it - 1; e.ph = p; fin = 1'b1;
        end
      end
      if (!fin && (it == c_at || it == int'(MAX_ITER))) begin
        e.kind = KDONE; e.iter = it; fin = 1'b1;
      end
    end
    end_q.push_back(e);
    timing_q.push_back(cyc + 1);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("launch_err_clr", 64'(err_o), 0);
    check("launch_halt_clr", 64'(halt_o), 0);
    check("launch_iter_clr", 64'(iter_count_o), 0);
    check("launch_busy", 64'(busy_o), 1);
    n = 0;
    while (end_q.size() != 0 && n < 3000) begin
      start_i = busy_o ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    check("solve_finished", 64'(end_q.size()), 0);
    repeat ($urandom_range(2, 5)) @(negedge clk);
    check("start_count", 64'(exp_start_q.size()), 0);
  endtask

  task automatic reset_in_launch();
    int n;
    conv_at  = MAX_ITER + 1;
    hang_it  = 0;
    abort_it = 0;
    solve_id++;
    exp_start_q.delete();
    end_q.delete();
    timing_q.delete();
    for (int it = 0; it < 2; it++) for (int p = 0; p < 7; p++) exp_start_q.push_back(p);
    timing_q.push_back(cyc + 1);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (!(unit_start_o != '0 && iter_count_o == 1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reset_launch_reached", 64'(n < 500), 1);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    exp_start_q.delete();
    end_q.delete();
    timing_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("post_reset_no_start", 64'(unit_start_o), 0);
      check("post_reset_idle", 64'(busy_o), 0);
    end
  endtask

  initial begin : driver
    int c;
    int lim;
    int k;
    int it;
    int ph;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    run_solve(MAX_ITER + 1, 0, 0, 0, 0);  // iteration limit: 21 launches
    run_solve(1, 0, 0, 0, 0);             // converge in first CHECK
    run_solve(MAX_ITER + 1, 1, 3, 0, 0);  // unit 3 hangs
    run_solve(MAX_ITER + 1, 0, 0, 2, 5);  // abort in WAIT, phase 5, iteration 2
    for (int s = 0; s < 20; s++) begin
      c   = int'($urandom_range(1, MAX_ITER + 1));
      lim = (c > int'(MAX_ITER)) ? int'(MAX_ITER) : c;
      k   = int'($urandom_range(0, 2));
      it  = int'($urandom_range(1, lim));
      ph  = int'($urandom_range(0, 6));
      case (k)
        0:       run_solve(c, 0, 0, 0, 0);
        1:       run_solve(c, it, ph, 0, 0);
        default: run_solve(c, 0, 0, it, ph);
      endcase
    end
    reset_in_launch();
    run_solve(2, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : global_timeout
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule

// File: doc/cg_phase_sequencer.md
Name: cg_phase_sequencer

Overview:
- Top-level phase scheduler for the conjugate-gradient solver datapath.
- Each iteration, it launches the compute units in fixed order and waits for each unit's done pulse before launching the next.
- Order: A·p matrix-vector, p·q dot product, alpha divide, x/r update, r·r dot product, beta divide, p update, then a convergence check.
- Counts iterations, halts on convergence or the iteration limit, and traps hung units with a per-phase watchdog.
- Sits above the memory-address control unit. Replaces ad-hoc finish/halt flag chains with one explicit FSM.

Parameters:
- MAX_ITER, 20: maximum CG iterations before forced halt; legal range 1..2^ITER_W-1.
- ITER_W, 11: width of the iteration counter.
- TIMEOUT_CYCLES, 4096: maximum WAIT cycles per phase before the error trap.
- TMO_W, 16: watchdog counter width; must hold TIMEOUT_CYCLES.
- PERF_W, 32: cycle-counter width (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start_i  in  1  begin a solve; sampled only in IDLE, DONE or ERROR
- abort_i  in  1  abandon the current solve and return to IDLE
- converged_i  in  1  residual below threshold; sampled only in CHECK
- unit_done_i  in  7  per-phase done pulses, indexed by phase number
- unit_start_o  out  7  one-hot, single-cycle launch pulse for the current phase
- phase_o  out  3  current phase index, 0..6
- iter_count_o  out  ITER_W  iterations completed in this solve
- busy_o  out  1  high in LAUNCH, WAIT and CHECK
- halt_o  out  1  solve finished; held until the next start_i
- done_o  out  1  one-cycle pulse on entry to DONE
- err_o  out  1  watchdog trap; held until start_i or reset
- err_phase_o  out  3  phase that timed out
- cycles_o  out  PERF_W  cycles spent in the solve (see Optional Feature)

Behaviour:
- Phase index: 0 MXV, 1 VXV_PQ, 2 DIV_ALPHA, 3 UPD_XR, 4 VXV_RR, 5 DIV_BETA, 6 UPD_P.
- States: IDLE, LAUNCH, WAIT, CHECK, DONE, ERROR.
- Reset: state IDLE, phase 0.
  - All outputs 0: unit_start_o, iter_count_o, busy_o, halt_o, done_o, err_o, err_phase_o, cycles_o.
  - Reset mid-operation takes effect on the next edge. No start or done pulses are emitted afterwards.
- IDLE/DONE/ERROR, start_i=1:
  - Next state LAUNCH, phase 0.
  - Clears iter_count_o, halt_o, err_o and err_phase_o.
- LAUNCH:
  - unit_start_o[phase] is high for exactly this one cycle (Moore-decoded from state).
  - Next state WAIT; watchdog cleared.
  - Latency: start_i seen at edge k gives unit_start_o[0] high during cycle k+1.
- WAIT:
  - Only unit_done_i[phase] is accepted.
  - Done bits for other phases are ignored, as is any done arriving during LAUNCH.
  - On done with phase<6: phase+1, next state LAUNCH. Back-to-back phases take 2 cycles minimum.
  - On done with phase==6: next state CHECK.
  - Watchdog increments each WAIT cycle. When it reaches TIMEOUT_CYCLES-1 without done, the next state is ERROR.
  - In ERROR: err_o=1, err_phase_o=phase, busy_o=0.
  - If done and timeout coincide, done wins.
- CHECK (1 cycle):
  - iter_count_o increments.
  - If converged_i=1, or the new count equals MAX_ITER: next state DONE, done_o pulses, halt_o=1.
  - Otherwise: phase 0, next state LAUNCH.
- start_i while busy is ignored.
- abort_i in any non-IDLE state: next state IDLE, phase 0, halt_o=0. No done_o pulse. iter_count_o is retained. abort_i has priority over start_i.
- Priority order: reset, then abort_i, then the watchdog/done logic.

Optional Feature:
- Macro: CG_SEQ_PERF_CNT_EN.
- Defined:
  - cycles_o clears on an accepted start_i.
  - It increments every cycle while busy_o=1 and saturates at all-ones.
  - It freezes in DONE, ERROR and after abort.
- Undefined: cycles_o is tied to 0 and no counter flops are synthesised. The port list is unchanged.

Decomposition:
- Package cg_seq_pkg holds:
  - state enum;
  - phase index constants (PH_MXV..PH_UPD_P);
  - NUM_PHASES=7;
  - PHASE_W=3.
- Sub-module cg_phase_watchdog:
  - inputs clear and enable;
  - output expired;
  - parameters TIMEOUT_CYCLES and TMO_W.

Test Plan:
- MAX_ITER=3; every unit returns done 2 cycles after its start; converged_i=0 → 21 start pulses in phase order 0..6 ×3; iter_count_o=3; done_o pulses once; halt_o=1.
- converged_i=1 in the first CHECK → halt after 7 start pulses; iter_count_o=1.
- TIMEOUT_CYCLES=8; withhold unit_done_i[3] → err_o=1 after 8 WAIT cycles; err_phase_o=3; no further starts; a new start_i clears err_o and relaunches phase 0.
- In WAIT at phase 2, pulse unit_done_i[4] → ignored; phase_o stays 2; unit_done_i[2] later advances to phase 3.
- abort_i in WAIT at phase 5 of iteration 2 → IDLE next cycle; busy_o=0; halt_o=0; iter_count_o=1; done_o never pulses.
- Reset asserted in LAUNCH → all outputs 0 next cycle; no start pulse follows until start_i.
